chip8_regfile_bulk: RTL

- Parametrised CHIP-8 V-register file with two registered read ports, one general write port and a dedicated flag-register (VF) write port.
- Built-in bulk-transfer sequencer implements FX55 (store V0..Vx to memory) and FX65 (load V0..Vx from memory) over a simple req/ack memory handshake, so the CPU FSM only issues one start pulse.
- Sits between the CPU control FSM/ALU and the memory arbiter.

---
 rtl/chip8_regfile_bulk_if.sv | 23 ++
 rtl/chip8_regfile_bulk.sv | 110 +++++++++++
 2 files changed

// File: rtl/chip8_regfile_bulk_if.sv
// Memory-side handshake of the V-register bulk sequencer: one beat per req/ack pair.
// Requester holds req, wr, idx and wdata stable until ack; rdata is valid with ack on loads.
interface chip8_regfile_bulk_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_idx, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_idx, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/chip8_regfile_bulk.sv
// CHIP-8 V-register file (2 registered read ports, write-through) with FX55/FX65 bulk sequencer.
// Reads take 1 cycle; each bulk beat waits for mem_ack, max one beat per cycle, CPU writes dropped while busy.
module chip8_regfile_bulk #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int FLAG_REG = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flag_we,
  input  logic [DATA_W-1:0] flag_data,
  input  logic [ADDR_W-1:0] rd_sel_a,
  input  logic [ADDR_W-1:0] rd_sel_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              bulk_start,
  input  logic              bulk_dir,
  input  logic [ADDR_W-1:0] bulk_last,
  output logic              busy,
  output logic              done,
  chip8_regfile_bulk_if.master mem
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] FLAG_IDX = ADDR_W'(FLAG_REG);

  typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;

  state_t                          state_q, state_d;
  logic                            dir_q, dir_d;
  logic [ADDR_W-1:0]               last_q, last_d;
  logic [ADDR_W-1:0]               idx_q, idx_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DATA_W-1:0]               rd_a_q, rd_a_d;
  logic [DATA_W-1:0]               rd_b_q, rd_b_d;
  logic                            load_we;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    last_d  = last_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    load_we = 1'b0;

    case (state_q)
      IDLE: begin
        if (bulk_start) begin
          dir_d   = bulk_dir;
          last_d  = bulk_last;
          idx_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (mem.mem_ack) begin
          load_we = dir_q;
          if (idx_q == last_q) state_d = FIN;
          else                 idx_d   = idx_q + ADDR_W'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Later assignments win: flag beats general write, sequencer load beats both.
    if (state_q == IDLE) begin
      if (wr_en)   regs_d[wr_sel]   = wr_data;
      if (flag_we) regs_d[FLAG_IDX] = flag_data;
    end
    if (load_we) regs_d[idx_q] = mem.mem_rdata;

    // Reading the next-state array gives write-through on the same edge.
    rd_a_d = regs_d[rd_sel_a];
    rd_b_d = regs_d[rd_sel_b];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      last_q  <= '0;
      idx_q   <= '0;
      regs_q  <= '0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      regs_q  <= regs_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
    end
  end

  assign rd_data_a     = rd_a_q;
  assign rd_data_b     = rd_b_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);
  assign mem.mem_req   = (state_q == XFER);
  assign mem.mem_wr    = (state_q == XFER) && !dir_q;
  assign mem.mem_idx   = idx_q;
  assign mem.mem_wdata = regs_q[idx_q];

endmodule
